// File: rtl/ad9866_spi_responder.sv
// ad9866_spi_responder
// SPI register-bank responder modelled on the AD9866 control port.
// A frame is 16 bits, MSB first: R/W, two ignored bits, a 5-bit address,
// then 8 data bits. Writes update an internal register bank, and register
// GAIN_ADDR bits [5:0] drive pga_gain. Reads shift the addressed register
// out on sdo.
//
// Build option: define AD9866_SPI_SYNC_EN to put 2-flop synchronizers on
// sclk, sen_n and sdio when the initiator runs from an unrelated clock.
// In that build, sclk high and low phases must each last at least 3 clk.
// Without the macro, the raw pins are used directly and sclk phases may be
// as short as 1 clk.
//
// Write-report semantics: reg_wr_strobe is high for exactly one clk for each
// accepted write. reg_wr_addr and reg_wr_data are valid in that same clk and
// hold their value until the next accepted write. There is no back-pressure.
module ad9866_spi_responder #(
  parameter int         NREGS     = 20,
  parameter logic [4:0] GAIN_ADDR = 5'h0a
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       sen_n,
  input  logic       sdio,
  output logic       sdo,
  output logic [5:0] pga_gain,
  output logic       reg_wr_strobe,
  output logic [4:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic sclk_s;
  logic sen_s;
  logic sdio_s;

`ifdef AD9866_SPI_SYNC_EN
  logic [1:0] sclk_sync;
  logic [1:0] sen_sync;
  logic [1:0] sdio_sync;

  // Two-flop synchronizers. All three pins share the same latency, so data
  // stays aligned with the sclk edge that qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      sen_sync  <= '0;
      sdio_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sen_sync  <= {sen_sync[0], sen_n};
      sdio_sync <= {sdio_sync[0], sdio};
    end
  end

  assign sclk_s = sclk_sync[1];
  assign sen_s  = sen_sync[1];
  assign sdio_s = sdio_sync[1];
`else
  assign sclk_s = sclk;
  assign sen_s  = sen_n;
  assign sdio_s = sdio;
`endif

  logic sclk_d;
  logic sen_d;

  // One-clk delayed copies for edge detection. sen_d resets low on purpose:
  // a sen_n still held low when reset is released produces no falling edge,
  // so the block waits for a fresh frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d <= 1'b0;
      sen_d  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      sen_d  <= sen_s;
    end
  end

  logic sen_fall;
  logic sen_rise;
  logic sclk_rise;
  logic sclk_fall;

  assign sen_fall  = sen_d & ~sen_s;
  assign sen_rise  = ~sen_d & sen_s;
  // sclk activity is only meaningful inside a frame (sen_n low).
  assign sclk_rise = sclk_s & ~sclk_d & ~sen_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~sen_s;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [6:0]  shift_sr;
  logic        rw;
  logic [4:0]  addr;
  logic [7:0]  rd_sr;
  logic [7:0]  regs [32];

  // The byte completed by the current sample: the seven earlier bits plus
  // the live sdio value.
  logic [7:0] byte_now;
  logic [4:0] addr_now;
  logic       addr_now_ok;
  logic       addr_ok;
  logic [7:0] rd_val;

  assign byte_now    = {shift_sr, sdio_s};
  assign addr_now    = byte_now[4:0];
  assign addr_now_ok = {27'd0, addr_now} < 32'(NREGS);
  assign addr_ok     = {27'd0, addr} < 32'(NREGS);
  assign rd_val      = addr_now_ok ? regs[addr_now] : 8'h00;

  // Register GAIN_ADDR. Unimplemented addresses never get written, so they
  // read as zero.
  assign pga_gain = regs[GAIN_ADDR][5:0];

  // Frame FSM, register bank and all registered outputs.
  // sen_n edges take priority over any sclk edge in the same clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 5'd0;
      shift_sr      <= 7'd0;
      rw            <= 1'b0;
      addr          <= 5'd0;
      rd_sr         <= 8'h00;
      sdo           <= 1'b0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= 5'd0;
      reg_wr_data   <= 8'h00;
      frame_err     <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else begin
      reg_wr_strobe <= 1'b0;
      frame_err     <= 1'b0;
      if (sen_rise) begin
        state <= IDLE;
        sdo   <= 1'b0;
        // ADDR and DATA both mean that fewer than 16 bits were counted.
        if (state == ADDR || state == DATA) frame_err <= 1'b1;
      end else if (sen_fall) begin
        state    <= ADDR;
        bit_cnt  <= 5'd0;
        shift_sr <= 7'd0;
        sdo      <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (sclk_rise) begin
              shift_sr <= byte_now[6:0];
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                state <= DATA;
                rw    <= byte_now[7];
                addr  <= addr_now;
                rd_sr <= rd_val;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_sr <= byte_now[6:0];
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                state <= DONE;
                sdo   <= 1'b0;
                if (!rw && addr_ok) begin
                  regs[addr]    <= byte_now;
                  reg_wr_strobe <= 1'b1;
                  reg_wr_addr   <= addr;
                  reg_wr_data   <= byte_now;
                end
              end
            end else if (sclk_fall && rw) begin
              sdo   <= rd_sr[7];
              rd_sr <= {rd_sr[6:0], 1'b0};
            end
          end
          DONE: begin
            // Bits beyond 16 are ignored. bit_cnt stays saturated at 16.
            sdo <= 1'b0;
          end
          default: begin
            sdo <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// tb_ad9866_spi_responder
// Bench for ad9866_spi_responder. It runs directed frames and random frames
// against a register-array reference model. The sclk phase length follows
// AD9866_SPI_SYNC_EN: 3 clk when the macro is defined, 1 clk otherwise.
`timescale 1ns/1ps
module tb_ad9866_spi_responder;

  localparam int         NREGS     = 20;
  localparam logic [4:0] GAIN_ADDR = 5'h0a;
`ifdef AD9866_SPI_SYNC_EN
  localparam int PH = 3;
`else
  localparam int PH = 1;
`endif

  // clock / reset block
  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       sen_n;
  logic       sdio;
  logic       sdo;
  logic [5:0] pga_gain;
  logic       reg_wr_strobe;
  logic [4:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       frame_err;

  always #5 clk = ~clk;

  ad9866_spi_responder #(
    .NREGS     (NREGS),
    .GAIN_ADDR (GAIN_ADDR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sclk          (sclk),
    .sen_n         (sen_n),
    .sdio          (sdio),
    .sdo           (sdo),
    .pga_gain      (pga_gain),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .frame_err     (frame_err)
  );

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  model_regs [32];
  int          err_seen = 0;
  int          strobe_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: count frame_err pulses and match each write strobe against the expected queue.
  always @(negedge clk) begin
    logic [12:0] e;
    if (frame_err === 1'b1) err_seen++;
    if (reg_wr_strobe === 1'b1) begin
      strobe_seen++;
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", 32'(reg_wr_strobe), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(reg_wr_addr), 32'(e[12:8]));
        check("wr_data", 32'(reg_wr_data), 32'(e[7:0]));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
    exp_q.delete();
  endtask

  // Shift out nbits of word with sen_n already low. The task checks sdo
  // before each rising sclk edge and collects the read byte.
  task automatic send_bits(input logic [15:0] word, input int nbits,
                           input logic [7:0] rdv, output logic [7:0] rd_got);
    logic exp_bit;
    rd_got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) sdio = word[15-i];
      else        sdio = 1'($urandom_range(0, 1));
      repeat (PH) @(negedge clk);
      if (i >= 8 && i < 16) begin
        rd_got[15-i] = sdo;
        exp_bit = word[15] ? rdv[15-i] : 1'b0;
      end else begin
        exp_bit = 1'b0;
      end
      check($sformatf("sdo_bit%0d", i), 32'(sdo), 32'(exp_bit));
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input logic [15:0] word, input int nbits, output logic [7:0] rd_got);
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] rdv;
    logic       commit;
    int         err0;
    int         s0;
    a      = word[12:8];
    d      = word[7:0];
    rdv    = (int'(a) < NREGS) ? model_regs[a] : 8'h00;
    commit = (nbits >= 16) && !word[15] && (int'(a) < NREGS);
    if (commit) exp_q.push_back({a, d});
    err0 = err_seen;
    s0   = strobe_seen;
    @(negedge clk);
    sen_n = 1'b0;
    repeat (2*PH) @(negedge clk);
    send_bits(word, nbits, rdv, rd_got);
    repeat (PH) @(negedge clk);
    sen_n = 1'b1;
    repeat (PH+4) @(negedge clk);
    if (commit) model_regs[a] = d;
    check("sdo_after_frame", 32'(sdo), 32'd0);
    check("frame_err_cnt", 32'(err_seen - err0), (nbits < 16) ? 32'd1 : 32'd0);
    check("strobe_cnt", 32'(strobe_seen - s0), commit ? 32'd1 : 32'd0);
    check("strobe_drained", 32'(exp_q.size()), 32'd0);
    check("pga_gain", 32'(pga_gain), 32'(model_regs[GAIN_ADDR][5:0]));
  endtask

  initial begin
    logic [7:0]  rd;
    logic [15:0] w;
    int          nb;
    int          err0;
    reset = 1'b1;
    sclk  = 1'b0;
    sen_n = 1'b1;
    sdio  = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);

    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_pga", 32'(pga_gain), 32'd0);
    check("rst_strobe", 32'(reg_wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    // Reset in the middle of a write frame aborts it silently.
    err0 = err_seen;
    @(negedge clk);
    sen_n = 1'b0;
    repeat (2*PH) @(negedge clk);
    send_bits(16'h0a3f, 12, 8'h00, rd);
    do_reset();
    sclk  = 1'b0;
    sen_n = 1'b1;
    repeat (PH+6) @(negedge clk);
    check("midrst_frame_err", 32'(err_seen - err0), 32'd0);
    check("midrst_pga", 32'(pga_gain), 32'd0);
    check("midrst_strobes", 32'(strobe_seen), 32'd0);
    do_frame(16'h0a41, 16, rd);
    check("midrst_pga_after", 32'(pga_gain), 32'h01);

    // Gain register write.
    do_frame(16'h0a5c, 16, rd);
    check("gain_write_pga", 32'(pga_gain), 32'h1c);
    check("gain_write_addr", 32'(reg_wr_addr), 32'h0a);
    check("gain_write_data", 32'(reg_wr_data), 32'h5c);

    // Write then read back.
    do_frame(16'h0721, 16, rd);
    do_frame(16'h8700, 16, rd);
    check("readback_0x07", 32'(rd), 32'h21);

    // Truncated write frame.
    do_frame(16'h0b20, 10, rd);
    do_frame(16'h8b00, 16, rd);
    check("truncated_0x0b", 32'(rd), 32'h00);

    // Unimplemented address.
    do_frame(16'h1f55, 16, rd);
    do_frame(16'h9f00, 16, rd);
    check("unimpl_0x1f", 32'(rd), 32'h00);

    // Extra clocks after bit 16 are ignored.
    do_frame(16'h0312, 19, rd);
    do_frame(16'h8300, 18, rd);
    check("overrun_0x03", 32'(rd), 32'h12);

    // Random frames, mostly complete, with some truncated or overrun.
    for (int n = 0; n < 70; n++) begin
      w = 16'($urandom());
      if ($urandom_range(0, 4) == 0) w[12:8] = GAIN_ADDR;
      if ($urandom_range(0, 9) < 7) nb = 16;
      else                          nb = $urandom_range(0, 18);
      do_frame(w, nb, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
